// File: rtl/ebus_pkg.sv
// ============================================================================
// Module      : ebus_pkg
// Description : Shared EBUS types and constants for the diagnostic reader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ebus_pkg;

    localparam int EBUS_WIDTH = 36;

    // Upper two octal digits of the 12x diagnostic read function group
    localparam logic [5:0] DIAG_FUNC_12X = 6'o12;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FUNC   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/ebus_parity36.sv
// ============================================================================
// Module      : ebus_parity36
// Description : Combinational odd-parity check over a 36-bit word plus parity.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ebus_parity36
    import ebus_pkg::*;
(
    input  logic [0:EBUS_WIDTH-1] d,
    input  logic                  parity,
    output logic                  perr
);

    // Odd parity: the 37 bits together must carry an odd number of ones
    assign perr = ~(^d ^ parity);

endmodule

`default_nettype wire

// File: rtl/ebus_diag_reader.sv
// ============================================================================
// Module      : ebus_diag_reader
// Description : Single diagnostic EBUS read sequencer (func 12x, settle, sample).
//               Parity checking is built only when EBUS_PARITY_CHECK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ebus_diag_reader
    import ebus_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
)
(
    input  logic                  clk_h,
    input  logic                  reset_h,
    input  logic                  rd_req_h,
    input  logic [2:0]            rd_sel_h,
    output logic                  rd_busy_h,
    output logic                  rd_ack_h,
    output logic [0:EBUS_WIDTH-1] rd_data_h,
    output logic                  rd_perr_h,
    output logic                  diag_read_func_12x_h,
    output logic                  diag_04_a_h,
    output logic                  diag_05_a_h,
    output logic                  diag_06_a_h,
    input  logic [0:EBUS_WIDTH-1] ebus_d_h,
    input  logic                  ebus_parity_h
);

    generate
        if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
            $error("ebus_diag_reader: SETTLE_CYCLES must be in 1..15");
        end
    endgenerate

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

    state_t      state;
    state_t      state_next;
    logic [3:0]  settle_cnt;
    logic [2:0]  sel;
    logic        perr_now;
    logic        func_active;

`ifdef EBUS_PARITY_CHECK_EN
    ebus_parity36 u_parity (
        .d      (ebus_d_h),
        .parity (ebus_parity_h),
        .perr   (perr_now)
    );
`else
    logic unused_parity;
    assign unused_parity = ebus_parity_h;
    assign perr_now      = 1'b0;
`endif

    always_ff @(posedge clk_h or posedge reset_h) begin
        if (reset_h) begin
            state      <= ST_IDLE;
            settle_cnt <= 4'd0;
            sel        <= 3'd0;
            rd_data_h  <= '0;
            rd_perr_h  <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && rd_req_h) begin
                sel <= rd_sel_h;
            end
            if (state == ST_FUNC) begin
                settle_cnt <= SETTLE_LOAD;
            end else if (state == ST_SETTLE) begin
                settle_cnt <= settle_cnt - 4'd1;
            end
            // The bus is only looked at here; it may glitch freely otherwise
            if (state == ST_SAMPLE) begin
                rd_data_h <= ebus_d_h;
                rd_perr_h <= perr_now;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (rd_req_h) state_next = ST_FUNC;
            ST_FUNC:   state_next = ST_SETTLE;
            ST_SETTLE: if (settle_cnt == 4'd1) state_next = ST_SAMPLE;
            ST_SAMPLE: state_next = ST_DONE;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        func_active          = 1'b0;
        rd_busy_h            = 1'b0;
        rd_ack_h             = 1'b0;
        diag_read_func_12x_h = 1'b0;
        diag_04_a_h          = 1'b0;
        diag_05_a_h          = 1'b0;
        diag_06_a_h          = 1'b0;
        func_active = (state == ST_FUNC) || (state == ST_SETTLE) || (state == ST_SAMPLE);
        rd_busy_h   = (state != ST_IDLE);
        rd_ack_h    = (state == ST_DONE);
        if (func_active) begin
            diag_read_func_12x_h = 1'b1;
            diag_04_a_h          = sel[2];
            diag_05_a_h          = sel[1];
            diag_06_a_h          = sel[0];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ebus_diag_reader.sv
// ============================================================================
// Module      : tb_ebus_diag_reader
// Description : Directed self-checking bench for ebus_diag_reader (SETTLE_CYCLES=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ebus_diag_reader;

    localparam int S = 4;

    logic        clk_h = 1'b0;
    logic        reset_h;
    logic        rd_req_h;
    logic [2:0]  rd_sel_h;
    logic        rd_busy_h;
    logic        rd_ack_h;
    logic [0:35] rd_data_h;
    logic        rd_perr_h;
    logic        diag_read_func_12x_h;
    logic        diag_04_a_h;
    logic        diag_05_a_h;
    logic        diag_06_a_h;
    logic [0:35] ebus_d_h;
    logic        ebus_parity_h;

    int tests  = 0;
    int failed = 0;

    ebus_diag_reader #(.SETTLE_CYCLES(S)) dut (
        .clk_h                (clk_h),
        .reset_h              (reset_h),
        .rd_req_h             (rd_req_h),
        .rd_sel_h             (rd_sel_h),
        .rd_busy_h            (rd_busy_h),
        .rd_ack_h             (rd_ack_h),
        .rd_data_h            (rd_data_h),
        .rd_perr_h            (rd_perr_h),
        .diag_read_func_12x_h (diag_read_func_12x_h),
        .diag_04_a_h          (diag_04_a_h),
        .diag_05_a_h          (diag_05_a_h),
        .diag_06_a_h          (diag_06_a_h),
        .ebus_d_h             (ebus_d_h),
        .ebus_parity_h        (ebus_parity_h)
    );

    always #5 clk_h = ~clk_h;

    function automatic logic exp_perr(input logic [0:35] d, input logic p);
`ifdef EBUS_PARITY_CHECK_EN
        return ~(^d ^ p);
`else
        return 1'b0;
`endif
    endfunction

    // Called just after a negedge in IDLE; returns just after the negedge of
    // the IDLE cycle that follows DONE. Cycle c counts negedges after accept.
    task automatic do_read(input string name, input logic [2:0] sel,
                           input logic [0:35] d, input logic p,
                           input logic [0:35] exp_d, input logic exp_pe);
        logic       exp_diag;
        logic [3:0] got_diag;
        logic [3:0] want_diag;
        rd_req_h = 1'b1; rd_sel_h = sel; ebus_d_h = d; ebus_parity_h = p;
        @(negedge clk_h);
        rd_req_h = 1'b0; rd_sel_h = ~sel;
        for (int c = 1; c <= S + 3; c++) begin
            if (c > 1) @(negedge clk_h);
            exp_diag  = (c <= S + 2);
            got_diag  = {diag_read_func_12x_h, diag_04_a_h, diag_05_a_h, diag_06_a_h};
            want_diag = exp_diag ? {1'b1, sel} : 4'b0000;
            tests++;
            if (got_diag !== want_diag || rd_busy_h !== 1'b1 || rd_ack_h !== (c == S + 3)) begin
                failed++;
                $display("FAIL %s cycle %0d: diag=%b busy=%b ack=%b, expected diag=%b busy=1 ack=%b",
                         name, c, got_diag, rd_busy_h, rd_ack_h, want_diag, (c == S + 3));
            end
        end
        tests++;
        if (rd_data_h !== exp_d || rd_perr_h !== exp_pe) begin
            failed++;
            $display("FAIL %s data: data=%o perr=%b, expected data=%o perr=%b",
                     name, rd_data_h, rd_perr_h, exp_d, exp_pe);
        end
        @(negedge clk_h);
        tests++;
        if (rd_busy_h !== 1'b0 || rd_ack_h !== 1'b0) begin
            failed++;
            $display("FAIL %s idle: busy=%b ack=%b, expected 0 0", name, rd_busy_h, rd_ack_h);
        end
    endtask

    task automatic test_reset();
        reset_h = 1'b1; rd_req_h = 1'b1; rd_sel_h = 3'b111;
        ebus_d_h = 36'o777777777777; ebus_parity_h = 1'b0;
        repeat (3) @(negedge clk_h);
        tests++;
        if ({rd_busy_h, rd_ack_h, rd_perr_h, diag_read_func_12x_h, diag_04_a_h,
             diag_05_a_h, diag_06_a_h} !== 7'b0 || rd_data_h !== 36'o0) begin
            failed++;
            $display("FAIL reset: busy=%b ack=%b perr=%b func=%b data=%o, expected all 0",
                     rd_busy_h, rd_ack_h, rd_perr_h, diag_read_func_12x_h, rd_data_h);
        end
        rd_req_h = 1'b0;
        reset_h  = 1'b0;
    endtask

    task automatic test_basic();
        do_read("basic", 3'b101, 36'o123456701234, 1'b1, 36'o123456701234,
                exp_perr(36'o123456701234, 1'b1));
        do_read("basic2", 3'b010, 36'o000000000077, 1'b0, 36'o000000000077,
                exp_perr(36'o000000000077, 1'b0));
    endtask

    task automatic test_ebus_outside_sample();
        rd_req_h = 1'b1; rd_sel_h = 3'b110; ebus_d_h = 36'o0; ebus_parity_h = 1'b1;
        @(negedge clk_h);
        rd_req_h = 1'b0;
        for (int c = 2; c <= S + 3; c++) begin
            @(negedge clk_h);
            if (c == 2) ebus_d_h = 36'o777777777777;
            if (c == S + 1) ebus_d_h = 36'o0;
            if (c <= S + 2) begin
                tests++;
                if (rd_data_h !== 36'o000000000077) begin
                    failed++;
                    $display("FAIL hold cycle %0d: data=%o, expected %o", c, rd_data_h,
                             36'o000000000077);
                end
            end
        end
        tests++;
        if (rd_ack_h !== 1'b1 || rd_data_h !== 36'o0) begin
            failed++;
            $display("FAIL settle_glitch: ack=%b data=%o, expected ack=1 data=0",
                     rd_ack_h, rd_data_h);
        end
        @(negedge clk_h);
    endtask

    task automatic test_back_to_back();
        int acks = 0, idles = 0, ack1 = 0, ack2 = 0, drain = 0;
        rd_req_h = 1'b1; rd_sel_h = 3'b001; ebus_d_h = 36'o5; ebus_parity_h = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk_h);
            if (rd_ack_h === 1'b1) begin
                acks++;
                if (acks == 1) ack1 = c;
                if (acks == 2) ack2 = c;
            end
            if (rd_busy_h !== 1'b1) idles++;
        end
        rd_req_h = 1'b0;
        tests++;
        if (acks != 2 || ack1 != 7 || ack2 != 15) begin
            failed++;
            $display("FAIL b2b acks: count=%0d at %0d,%0d, expected 2 at 7,15", acks, ack1, ack2);
        end
        tests++;
        if (idles != 2) begin
            failed++;
            $display("FAIL b2b gap: idle cycles=%0d, expected 2", idles);
        end
        while (rd_busy_h === 1'b1 && drain < 20) begin
            @(negedge clk_h);
            drain++;
        end
        tests++;
        if (rd_busy_h !== 1'b0 || drain != 4) begin
            failed++;
            $display("FAIL b2b drain: busy=%b after %0d cycles, expected busy=0 after 4",
                     rd_busy_h, drain);
        end
    endtask

    task automatic test_reset_mid();
        rd_req_h = 1'b1; rd_sel_h = 3'b111; ebus_d_h = 36'o1234; ebus_parity_h = 1'b0;
        @(negedge clk_h);
        rd_req_h = 1'b0;
        repeat (2) @(negedge clk_h);
        #2 reset_h = 1'b1;
        #1;
        tests++;
        if ({rd_busy_h, rd_ack_h, rd_perr_h, diag_read_func_12x_h, diag_04_a_h,
             diag_05_a_h, diag_06_a_h} !== 7'b0 || rd_data_h !== 36'o0) begin
            failed++;
            $display("FAIL reset_mid: busy=%b ack=%b func=%b data=%o, expected all 0",
                     rd_busy_h, rd_ack_h, diag_read_func_12x_h, rd_data_h);
        end
        @(negedge clk_h);
        reset_h = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_h);
            tests++;
            if (rd_ack_h !== 1'b0 || rd_busy_h !== 1'b0) begin
                failed++;
                $display("FAIL reset_mid no_ack %0d: ack=%b busy=%b, expected 0 0",
                         c, rd_ack_h, rd_busy_h);
            end
        end
        do_read("after_reset", 3'b011, 36'o400000000001, 1'b1, 36'o400000000001,
                exp_perr(36'o400000000001, 1'b1));
    endtask

    task automatic test_parity();
`ifdef EBUS_PARITY_CHECK_EN
        do_read("parity_bad", 3'b000, 36'o1, 1'b1, 36'o1, 1'b1);
        do_read("parity_ok", 3'b000, 36'o1, 1'b0, 36'o1, 1'b0);
        do_read("parity_zero", 3'b100, 36'o0, 1'b0, 36'o0, 1'b1);
`else
        do_read("parity_bad", 3'b000, 36'o1, 1'b1, 36'o1, 1'b0);
        do_read("parity_ok", 3'b000, 36'o1, 1'b0, 36'o1, 1'b0);
        do_read("parity_zero", 3'b100, 36'o0, 1'b0, 36'o0, 1'b0);
`endif
    endtask

    task automatic test_ignore_busy();
        rd_req_h = 1'b1; rd_sel_h = 3'b011; ebus_d_h = 36'o42; ebus_parity_h = 1'b1;
        @(negedge clk_h);
        rd_req_h = 1'b0;
        repeat (S + 1) @(negedge clk_h);
        rd_req_h = 1'b1; rd_sel_h = 3'b100;
        #1;
        tests++;
        if ({diag_read_func_12x_h, diag_04_a_h, diag_05_a_h, diag_06_a_h} !== 4'b1011) begin
            failed++;
            $display("FAIL ignore_sel: diag=%b, expected 1011",
                     {diag_read_func_12x_h, diag_04_a_h, diag_05_a_h, diag_06_a_h});
        end
        @(negedge clk_h);
        tests++;
        if (rd_ack_h !== 1'b1 || rd_data_h !== 36'o42) begin
            failed++;
            $display("FAIL ignore_ack: ack=%b data=%o, expected ack=1 data=42", rd_ack_h, rd_data_h);
        end
        rd_req_h = 1'b0;
        @(negedge clk_h);
        tests++;
        if (rd_busy_h !== 1'b0 || diag_read_func_12x_h !== 1'b0) begin
            failed++;
            $display("FAIL ignore_queue: busy=%b func=%b, expected 0 0",
                     rd_busy_h, diag_read_func_12x_h);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ebus_outside_sample();
        test_back_to_back();
        test_reset_mid();
        test_parity();
        test_ignore_busy();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire
